imm_field_packer: RTL

Encoder-side counterpart of the immediate/displacement sign extenders: accepts a 32-bit signed value plus an instruction header, checks that the value fits the signed 18-bit immediate field or the signed 22-bit memory-displacement field, and packs header and field into a 32-bit instruction word. Sits in front of instruction memory or the instruction-generation path. A 2-entry output FIFO with valid/ready on both sides decouples it from the consumer. Out-of-range values are flagged and counted, never silently dropped.

---
 rtl/imm_field_packer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/imm_field_packer.sv
`default_nettype none
// ============================================================================
// Module      : imm_field_packer
// Description : Range-checks a 32-bit signed value against the signed 18-bit
//               immediate field or the signed 22-bit memory-displacement
//               field, packs it with an instruction header into a 32-bit word
//               and queues the result in a 2-entry valid/ready output FIFO.
//               Values that do not fit are still packed (by truncation),
//               flagged per entry and counted in saturating statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_field_packer (
  input  logic        clk,
  input  logic        rst_n,
  // producer side
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_mode,
  input  logic [13:0] in_hdr,
  input  logic [31:0] in_value,
  // consumer side
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic        out_ovf,
  // statistics
  output logic        ovf_sticky,
  output logic [15:0] ovf_count,
  input  logic        stat_clr
);

  localparam logic       C_MODE_IMM  = 1'b0;
  localparam logic [1:0] C_DEPTH     = 2'd2;
  localparam logic [15:0] C_CNT_MAX  = 16'hFFFF;

  // --------------------------------------------------------------------------
  // Packing and range check
  // --------------------------------------------------------------------------
  logic [31:0] w_word;
  logic        w_ovf;
  logic [14:0] w_imm_top;   // value bits [31:17]: must all equal the imm sign
  logic [10:0] w_md_top;    // value bits [31:21]: must all equal the md sign

  assign w_imm_top = in_value[31:17];
  assign w_md_top  = in_value[31:21];

  // Select the field layout and the fit check from the requested mode.
  always_comb begin
    w_word = 32'd0;
    w_ovf  = 1'b0;
    if (in_mode == C_MODE_IMM) begin
      w_word = {in_hdr[13:0], in_value[17:0]};
      w_ovf  = !((w_imm_top == 15'h0000) || (w_imm_top == 15'h7FFF));
    end else begin
      // md uses only the low 10 header bits; [13:10] are ignored.
      w_word = {in_hdr[9:0], in_value[21:0]};
      w_ovf  = !((w_md_top == 11'h000) || (w_md_top == 11'h7FF));
    end
  end

  // --------------------------------------------------------------------------
  // 2-entry output FIFO
  // --------------------------------------------------------------------------
  logic [31:0] r_mem_word0;
  logic [31:0] r_mem_word1;
  logic        r_mem_ovf0;
  logic        r_mem_ovf1;
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;

  logic        w_push;
  logic        w_pop;

  // Ready and valid come only from registered occupancy, so there is no
  // combinational path from out_ready back to in_ready.
  assign in_ready  = (r_count != C_DEPTH);
  assign out_valid = (r_count != 2'd0);

  // A full FIFO never pushes, even when it pops in the same cycle.
  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  // Head entry is read straight from storage, so it stays stable while
  // the consumer stalls.
  assign out_word = r_rd_ptr ? r_mem_word1 : r_mem_word0;
  assign out_ovf  = r_rd_ptr ? r_mem_ovf1  : r_mem_ovf0;

  // Storage write: the packed word and its overflow flag land at the tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_word0 <= 32'd0;
      r_mem_word1 <= 32'd0;
      r_mem_ovf0  <= 1'b0;
      r_mem_ovf1  <= 1'b0;
    end else if (w_push) begin
      if (r_wr_ptr) begin
        r_mem_word1 <= w_word;
        r_mem_ovf1  <= w_ovf;
      end else begin
        r_mem_word0 <= w_word;
        r_mem_ovf0  <= w_ovf;
      end
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally mod 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Overflow statistics
  // --------------------------------------------------------------------------
  logic        r_ovf_sticky;
  logic [15:0] r_ovf_count;
  logic        w_ovf_event;

  assign w_ovf_event = w_push && w_ovf;
  assign ovf_sticky  = r_ovf_sticky;
  assign ovf_count   = r_ovf_count;

  // Clear wins over a same-cycle overflow; the counter saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_sticky <= 1'b0;
      r_ovf_count  <= 16'd0;
    end else if (stat_clr) begin
      r_ovf_sticky <= 1'b0;
      r_ovf_count  <= 16'd0;
    end else if (w_ovf_event) begin
      r_ovf_sticky <= 1'b1;
      if (r_ovf_count != C_CNT_MAX) begin
        r_ovf_count <= r_ovf_count + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire
